sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of stored words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4; DEPTH = 2^ADDR_WIDTH entries.
REQ-003 SHALL have parameter AF_LEVEL, default 12, almost-full threshold; legal range AE_LEVEL < AF_LEVEL <= DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold; legal range 0 <= AE_LEVEL < AF_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 RST  in  1  reset, asynchronous, active-low.
REQ-008 W_INC  in  1  write request.
REQ-009 WR_DATA  in  DATA_WIDTH  write data.
REQ-010 R_INC  in  1  read request.
REQ-011 CLR_ERR  in  1  clears sticky error flags.
REQ-012 RD_DATA  out  DATA_WIDTH  read data.
REQ-013 FULL / EMPTY  out  1 each  occupancy == DEPTH / occupancy == 0.
REQ-014 ALMOST_FULL / ALMOST_EMPTY  out  1 each  occupancy >= AF_LEVEL / occupancy <= AE_LEVEL.
REQ-015 COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 OVERFLOW / UNDERFLOW  out  1 each  sticky error flags.

Function
REQ-017 Write SHALL be accepted iff W_INC=1 and FULL=0; WR_DATA stored at write pointer, write pointer +1 modulo DEPTH.
REQ-018 Read SHALL be accepted iff R_INC=1 and EMPTY=0; read pointer +1 modulo DEPTH.
REQ-019 W_INC while FULL=1 SHALL be dropped (no pointer/memory change) even if a read is accepted that cycle.
REQ-020 R_INC while EMPTY=1 SHALL be dropped (no pointer change) even if a write is accepted that cycle.
REQ-021 COUNT SHALL be registered: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-022 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY SHALL be decoded from registered COUNT only (no input-to-flag combinational path).
REQ-023 A write accepted at edge N SHALL be reflected in COUNT/flags after edge N.
REQ-024 FWFT=0: RD_DATA SHALL be a register loaded with the word at the read pointer on the edge that accepts a read, holding its value otherwise.
REQ-025 FWFT=1: RD_DATA SHALL equal the word at the read pointer whenever EMPTY=0, all-zeros when EMPTY=1; accepted read advances to next word.
REQ-026 Pointer wrap DEPTH-1 -> 0 SHALL be seamless; data order preserved across wrap.
REQ-027 OVERFLOW SHALL set on the edge following W_INC=1 with FULL=1; UNDERFLOW likewise for R_INC=1 with EMPTY=1.
REQ-028 CLR_ERR=1 SHALL clear both flags on next edge; a same-cycle set condition SHALL win over clear.

Reset
REQ-029 RST=0 SHALL immediately force pointers and COUNT to 0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0.
REQ-030 Storage array SHALL NOT be reset; reset mid-operation discards all contents (FIFO reads empty afterwards).
REQ-031 First accepted operation SHALL be on the first rising edge after RST deasserts.

Verification
REQ-032 Defaults, FWFT=0: write 0x11,0x22,0x33, then 3 reads -> RD_DATA 0x11,0x22,0x33 one edge after each read, COUNT 3->0, EMPTY=1 at end.
REQ-033 Fill 16 words -> ALMOST_FULL=1 once COUNT=12, FULL=1 at COUNT=16; 17th W_INC -> COUNT stays 16, OVERFLOW=1; CLR_ERR pulse -> OVERFLOW=0.
REQ-034 COUNT=5, W_INC=R_INC=1 for 20 cycles with incrementing data -> COUNT stays 5, pointers wrap, read order matches write order.
REQ-035 Empty FIFO, R_INC=1 and W_INC=1 same cycle (data 0xA5) -> read dropped, UNDERFLOW=1, COUNT=1, EMPTY=0; FWFT=1 variant: RD_DATA=0xA5 after that edge.
REQ-036 COUNT=10, RST pulsed low mid-cycle -> outputs at reset values immediately, no edge required; subsequent write/read of 0x5C returns 0x5C.

Source files
------------

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with registered occupancy count, threshold
// flags, sticky overflow/underflow errors and a selectable read mode:
// registered read (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_inc,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  r_inc,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Flags come only from the registered count, so no input reaches them
   // combinationally; acceptance is gated by those registered flags.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign wr_acc       = w_inc & ~full;
   assign rd_acc       = r_inc & ~empty;

   // Storage is deliberately not reset; pointers/count define validity.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally at DEPTH because they are ADDR_WIDTH bits wide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Occupancy: simultaneous accepted read and write leave it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error flags; a new error in the same cycle beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_inc && full)  overflow <= 1'b1;
         else if (clr_err)   overflow <= 1'b0;
         if (r_inc && empty) underflow <= 1'b1;
         else if (clr_err)   underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; zeros when nothing is stored.
         always_comb begin
            rd_data = empty ? '0 : mem[rd_ptr];
         end
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] rd_data_q;

         // Output register captures the head word on each accepted read.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_q <= '0;
            end else if (rd_acc) begin
               rd_data_q <= mem[rd_ptr];
            end
         end

         assign rd_data = rd_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: one registered-read and one FWFT
// instance share the same stimulus and are compared against a queue model.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          w_inc;
   logic [DW-1:0] wr_data;
   logic          r_inc;
   logic          clr_err;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          full0, empty0, af0, ae0, ovf0, udf0;
   logic          full1, empty1, af1, ae1, ovf1, udf1;
   logic [AW:0]   count0, count1;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] rd0_m;
   logic          ovf_m;
   logic          udf_m;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_reg (
      .clk(clk), .rst_n(rst_n), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
      .clr_err(clr_err), .rd_data(rd_data0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
      .clr_err(clr_err), .rd_data(rd_data1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(udf1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      rd0_m = '0;
      ovf_m = 1'b0;
      udf_m = 1'b0;
   endtask

   task automatic check_all();
      int n;
      logic [DW-1:0] head;
      n    = q.size();
      head = (n > 0) ? q[0] : '0;
      check("count",        32'(count0), 32'(n));
      check("full",         32'(full0),  32'(n == DEPTH));
      check("empty",        32'(empty0), 32'(n == 0));
      check("almost_full",  32'(af0),    32'(n >= AF));
      check("almost_empty", 32'(ae0),    32'(n <= AE));
      check("overflow",     32'(ovf0),   32'(ovf_m));
      check("underflow",    32'(udf0),   32'(udf_m));
      check("rd_data_reg",  32'(rd_data0), 32'(rd0_m));
      check("count_fwft",   32'(count1), 32'(n));
      check("empty_fwft",   32'(empty1), 32'(n == 0));
      check("ovf_fwft",     32'(ovf1),   32'(ovf_m));
      check("udf_fwft",     32'(udf1),   32'(udf_m));
      check("rd_data_fwft", 32'(rd_data1), 32'(head));
   endtask

   // One clock: drive inputs, advance the model across the edge, then check.
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      int  n;
      bit  is_full;
      bit  is_empty;
      w_inc   = w;
      wr_data = d;
      r_inc   = r;
      clr_err = c;
      @(posedge clk);
      n        = q.size();
      is_full  = (n == DEPTH);
      is_empty = (n == 0);
      if (w && is_full)  ovf_m = 1'b1;
      else if (c)        ovf_m = 1'b0;
      if (r && is_empty) udf_m = 1'b1;
      else if (c)        udf_m = 1'b0;
      if (r && !is_empty) rd0_m = q.pop_front();
      if (w && !is_full)  q.push_back(d);
      #1;
      check_all();
   endtask

   initial begin
      logic [DW-1:0] seq;
      rst_n   = 1'b0;
      w_inc   = 1'b0;
      r_inc   = 1'b0;
      clr_err = 1'b0;
      wr_data = '0;
      model_reset();

      // Reset state, then release between edges
      #12;
      check_all();
      rst_n = 1'b1;

      // Three writes then three reads in order
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("first_read", 32'(rd_data0), 32'h11);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("third_read", 32'(rd_data0), 32'h33);
      check("empty_end",  32'(empty0),   32'h1);

      // Fill to full, then one write too many, then clear the error
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      check("overflow_set", 32'(ovf0), 32'h1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("overflow_clr", 32'(ovf0), 32'h0);

      // Drain to 5, then 20 cycles of simultaneous read/write across the wrap
      for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      seq = 8'h40;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, seq, 1'b1, 1'b0);
         seq = seq + 8'h01;
      end
      check("count_steady", 32'(count0), 32'd5);

      // Drain, then read+write on empty: read dropped, underflow flagged
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'hA5, 1'b1, 1'b0);
      check("udf_same_cycle", 32'(udf0),     32'h1);
      check("fwft_a5",        32'(rd_data1), 32'hA5);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Random traffic, biased towards filling and then towards draining
      for (int i = 0; i < 400; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 75 : 25;
         cycle($urandom_range(0, 99) < wp, DW'($urandom),
               $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 15) == 0);
      end

      // Reach occupancy 10, then an asynchronous reset between edges
      while (q.size() > 10) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      while (q.size() < 10) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      w_inc = 1'b0;
      r_inc = 1'b0;
      clr_err = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #2;
      rst_n = 1'b1;
      cycle(1'b1, 8'h5C, 1'b0, 1'b0);
      check("fwft_5c", 32'(rd_data1), 32'h5C);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("read_5c", 32'(rd_data0), 32'h5C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
